mult32a_ctrl: RTL
=================

# mult32a_ctrl

Sequencing and arbitration controller for the 32-bit bit-serial add-shift multiplier core. It accepts parallel multiply requests from two requesters and grants them round-robin. For each granted request it clears the core, streams the multiplier operand into it one bit per cycle (LSB first), drains the upper product bits, and deserialises the 2·WIDTH-bit product. The result is returned through a valid/ready response port tagged with the requester ID.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits; core serial length.
- CORE_LAT, 0, cycles from core_bit driven to the matching core_prod_bit (0 = combinational core output).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  controller accepts requester 0 this cycle.
- req0_a  in  WIDTH  multiplicand (parallel) from requester 0.
- req0_b  in  WIDTH  multiplier (serialised) from requester 0.
- req1_valid / req1_ready / req1_a / req1_b  same widths and meaning, requester 1.
- core_clr  out  1  synchronous clear of core accumulator/carry state.
- core_mcand  out  WIDTH  parallel multiplicand held stable for the whole operation.
- core_bit  out  1  serial multiplier bit into core.
- core_prod_bit  in  1  serial product bit from core, LSB first.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer takes product.
- rsp_id  out  1  requester that owns rsp_prod.
- rsp_prod  out  2·WIDTH  deserialised product.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, RESP.
- IDLE: if any req*_valid, assert exactly one req*_ready (combinational from valid and arbiter pointer). Handshake = valid & ready. On handshake, latch a→core_mcand, b→shift register, grant→rsp_id; go to CLEAR.
- Arbitration: round-robin on last_grant (reset 1, so req0 wins first tie). Both valid → grant !last_grant. Only one valid → that one. last_grant updates on each handshake.
- CLEAR: core_clr=1 for exactly one cycle, core_bit=0; go to FEED; bit counter=0.
- FEED: WIDTH cycles; core_bit = b shift-register LSB, shift right each cycle; go to DRAIN after bit WIDTH-1.
- DRAIN: WIDTH+CORE_LAT cycles; core_bit=0; core_mcand unchanged; go to RESP.
- Capture: product bit j (0..2·WIDTH-1) sampled from core_prod_bit in the cycle WIDTH-relative index j+CORE_LAT after first FEED cycle; shifted into rsp_prod from MSB side so that after 2·WIDTH samples bit j sits at rsp_prod[j]. Samples taken only in FEED/DRAIN; no sample before index CORE_LAT.
- RESP: rsp_valid=1, rsp_prod/rsp_id stable until rsp_ready; on handshake go to IDLE. No request accepted in the handshake cycle; earliest next accept is the following cycle.
- Controller does not interpret sign; the product value is whatever the core emits over 2·WIDTH bits.
- Counter width: ceil(log2(WIDTH+CORE_LAT+1)); no wrap beyond terminal count.

## Timing
- Reset values: state IDLE, req0_ready=req1_ready=0 during rst, rsp_valid=0, rsp_id=0, rsp_prod=0, core_mcand=0, core_bit=0, busy=0, core_clr=1 while rst high (core cleared with controller).
- Accept at cycle 0 → CLEAR cycle 1 → FEED cycles 2..WIDTH+1 (core_bit=b[k] at cycle 2+k) → DRAIN cycles WIDTH+2..2·WIDTH+1+CORE_LAT → rsp_valid first high at cycle 2·WIDTH+2+CORE_LAT (66 for defaults).
- Throughput: one operation per 2·WIDTH+3+CORE_LAT cycles minimum when rsp_ready held high.
- rsp_ready low: RESP holds indefinitely; req*_ready stay 0; pending requests wait, no loss.
- req*_valid dropping before handshake: no grant; arbiter pointer unchanged.
- rst asserted in any state: next cycle is IDLE with reset values; in-flight operation discarded, no rsp_valid.

## Test plan
- Single req0, a=3, b=5, rsp_ready=1, unsigned behavioural core → rsp_valid at cycle 66, rsp_prod=15, rsp_id=0, req0_ready high only in cycle 0.
- a=0xFFFFFFFF, b=0xFFFFFFFF → rsp_prod=0xFFFFFFFE00000001; core_clr pulse exactly one cycle before first core_bit.
- Both valid continuously, distinct operands → grants alternate 0,1,0,1; each rsp_id and rsp_prod match the owner's operands.
- rsp_ready held low 10 cycles after rsp_valid → rsp_prod stable, no req*_ready; accept occurs the cycle after rsp handshake.
- rst pulsed at cycle 20 of an operation → busy=0, rsp_valid=0 next cycle; new request a=7, b=6 then gives rsp_prod=42.
- CORE_LAT=2 with 2-cycle delayed core model, a=123456, b=789 → rsp_prod=97406784, rsp_valid at cycle 68.

Source files
------------

// File: rtl/mult32a_ctrl.sv
// Sequencing/arbitration controller for a bit-serial add-shift multiplier core.
// Two requesters are served round-robin; the product is deserialised and returned over valid/ready.
module mult32a_ctrl #(
    parameter int WIDTH    = 32,
    parameter int CORE_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 core_clr,
    output logic [WIDTH-1:0]     core_mcand,
    output logic                 core_bit,
    input  logic                 core_prod_bit,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_prod,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH + CORE_LAT + 1);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIDTH + CORE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        RESP
    } state_t;

    state_t state, state_next;

    logic                 last_grant;
    logic                 grant_valid;
    logic                 grant_id;
    logic                 accept;
    logic                 sample;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     b_shift;
    logic                 id_q;
    logic [2*WIDTH-1:0]   prod;
    logic [CNT_W-1:0]     cnt;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        core_clr   = 1'b0;
        core_bit   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        sample     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!rst && grant_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                core_clr   = 1'b1;
                state_next = FEED;
            end
            FEED: begin
                core_bit = b_shift[0];
                sample   = (int'(cnt) >= CORE_LAT);
                if (cnt == FEED_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Sample index keeps counting from the FEED phase, offset by WIDTH.
                sample = (int'(cnt) + WIDTH >= CORE_LAT);
                if (cnt == DRAIN_LAST) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            core_clr = 1'b1;
            core_bit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            mcand      <= '0;
            b_shift    <= '0;
            id_q       <= 1'b0;
            prod       <= '0;
            cnt        <= '0;
        end else begin
            if (accept) begin
                mcand      <= grant_id ? req1_a : req0_a;
                b_shift    <= grant_id ? req1_b : req0_b;
                id_q       <= grant_id;
                last_grant <= grant_id;
            end
            case (state)
                CLEAR: begin
                    cnt <= '0;
                end
                FEED: begin
                    b_shift <= b_shift >> 1;
                    if (cnt == FEED_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (cnt != DRAIN_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
            // Product enters from the MSB side so the first sample ends up in bit 0.
            if (sample) begin
                prod <= {core_prod_bit, prod[2*WIDTH-1:1]};
            end
        end
    end

    assign core_mcand = mcand;
    assign rsp_id     = id_q;
    assign rsp_prod   = prod;

endmodule
